// File: rtl/paddle_oneshot_ctrl.sv
// Paired scanline-counted one-shots that replace the two 555 paddle timers.
// Each pulse width is LINE_OFFSET plus a latched position, and a PAD_TRG_N fall starts both pulses.
//   state  | meaning
//   IDLE   | both outputs low, waiting for a PAD_TRG_N high-to-low edge
//   TIMING | at least one output high, counting HRESET rising edges
module paddle_oneshot_ctrl #(
  parameter int LINE_OFFSET = 16,
  parameter int POS_MAX     = 200,
  parameter int CNT_W       = 9
) (
  input  logic       CLK,
  input  logic       FPGA_RESET_N,
  input  logic       PAD_TRG_N,
  input  logic       HRESET,
  input  logic       POS_WE,
  input  logic [7:0] PAD1_POS,
  input  logic [7:0] PAD2_POS,
  output logic       PAD1_OUT,
  output logic       PAD2_OUT,
  output logic       BUSY
);

  typedef enum logic {IDLE, TIMING} state_t;

  localparam logic [CNT_W-1:0] OFFSET  = CNT_W'(LINE_OFFSET);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0]       POS_CAP = 8'(POS_MAX);

  state_t           state;
  logic             prev_trg, prev_hr;
  logic             trg_fall, line_tick;
  logic [7:0]       shadow1, shadow2, active1, active2;
  logic [CNT_W-1:0] cnt, cnt_inc, target1, target2;
  logic             out1_nxt, out2_nxt;

  assign trg_fall  = prev_trg & ~PAD_TRG_N;
  assign line_tick = ~prev_hr & HRESET;
  assign BUSY      = PAD1_OUT | PAD2_OUT;

  // Saturating increment: an unreachable target still ends the pulse at CNT_MAX.
  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
  assign target1 = OFFSET + CNT_W'(active1);
  assign target2 = OFFSET + CNT_W'(active2);

  always_comb begin
    out1_nxt = PAD1_OUT;
    out2_nxt = PAD2_OUT;
    if (line_tick) begin
      if (cnt_inc == target1 || cnt_inc == CNT_MAX) out1_nxt = 1'b0;
      if (cnt_inc == target2 || cnt_inc == CNT_MAX) out2_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge FPGA_RESET_N) begin
    if (!FPGA_RESET_N) begin
      prev_trg <= 1'b0;
      prev_hr  <= 1'b0;
    end else begin
      prev_trg <= PAD_TRG_N;
      prev_hr  <= HRESET;
    end
  end

  always_ff @(posedge CLK or negedge FPGA_RESET_N) begin
    if (!FPGA_RESET_N) begin
      shadow1 <= '0;
      shadow2 <= '0;
    end else if (POS_WE) begin
      shadow1 <= (PAD1_POS > POS_CAP) ? POS_CAP : PAD1_POS;
      shadow2 <= (PAD2_POS > POS_CAP) ? POS_CAP : PAD2_POS;
    end
  end

  // Retriggers during TIMING are ignored; shadow writes only land on the next trigger.
  always_ff @(posedge CLK or negedge FPGA_RESET_N) begin
    if (!FPGA_RESET_N) begin
      state    <= IDLE;
      cnt      <= '0;
      active1  <= '0;
      active2  <= '0;
      PAD1_OUT <= 1'b0;
      PAD2_OUT <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trg_fall) begin
            active1  <= shadow1;
            active2  <= shadow2;
            cnt      <= '0;
            PAD1_OUT <= 1'b1;
            PAD2_OUT <= 1'b1;
            state    <= TIMING;
          end
        end
        TIMING: begin
          if (line_tick) cnt <= cnt_inc;
          PAD1_OUT <= out1_nxt;
          PAD2_OUT <= out2_nxt;
          if (!out1_nxt && !out2_nxt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_oneshot_ctrl.sv
// Self-checking bench for paddle_oneshot_ctrl: table of position/width frames plus corner sequences.
module tb_paddle_oneshot_ctrl;

  logic       CLK = 1'b0;
  logic       FPGA_RESET_N;
  logic       PAD_TRG_N;
  logic       HRESET;
  logic       POS_WE;
  logic [7:0] PAD1_POS, PAD2_POS;
  logic       PAD1_OUT, PAD2_OUT, BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    int         w1;
    int         w2;
  } vec_t;

  typedef struct {
    int w1;
    int w2;
  } exp_t;

  exp_t sb[$];

  paddle_oneshot_ctrl dut (
    .CLK(CLK), .FPGA_RESET_N(FPGA_RESET_N), .PAD_TRG_N(PAD_TRG_N), .HRESET(HRESET),
    .POS_WE(POS_WE), .PAD1_POS(PAD1_POS), .PAD2_POS(PAD2_POS),
    .PAD1_OUT(PAD1_OUT), .PAD2_OUT(PAD2_OUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic line_tick();
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    step();
  endtask

  task automatic write_pos(input logic [7:0] p1, input logic [7:0] p2);
    PAD1_POS = p1;
    PAD2_POS = p2;
    POS_WE   = 1'b1;
    step();
    POS_WE   = 1'b0;
  endtask

  // Drives a high-to-low trigger, optionally with a same-cycle write, and queues the expected widths.
  task automatic trigger(input int w1, input int w2, input bit wr, input logic [7:0] p1,
                         input logic [7:0] p2);
    exp_t e;
    PAD_TRG_N = 1'b1;
    step();
    step();
    PAD_TRG_N = 1'b0;
    if (wr) begin
      PAD1_POS = p1;
      PAD2_POS = p2;
      POS_WE   = 1'b1;
    end
    check("pre_rise_out1", PAD1_OUT, 0);
    step();
    POS_WE = 1'b0;
    check("rise_out1", PAD1_OUT, 1);
    check("rise_out2", PAD2_OUT, 1);
    check("rise_busy", BUSY, 1);
    e.w1 = w1;
    e.w2 = w2;
    sb.push_back(e);
  endtask

  // Counts line ticks until both outputs fall, then compares against the queued widths.
  task automatic measure(input int retrig_at, input int wr_at, input logic [7:0] m1,
                         input logic [7:0] m2);
    int   f1 = 0;
    int   f2 = 0;
    exp_t e;
    for (int k = 1; k <= 400; k++) begin
      line_tick();
      if (f1 == 0 && !PAD1_OUT) f1 = k;
      if (f2 == 0 && !PAD2_OUT) f2 = k;
      if (BUSY != (PAD1_OUT | PAD2_OUT)) check("busy_or", BUSY, PAD1_OUT | PAD2_OUT);
      if (k == retrig_at) begin
        PAD_TRG_N = 1'b1;
        step();
        PAD_TRG_N = 1'b0;
        step();
        check("retrig_out1", PAD1_OUT, (f1 == 0) ? 1 : 0);
        check("retrig_out2", PAD2_OUT, (f2 == 0) ? 1 : 0);
      end
      if (k == wr_at) write_pos(m1, m2);
      if (f1 != 0 && f2 != 0) break;
    end
    if (f1 == 0 || f2 == 0) check("timeout_no_fall", 0, 1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("width_out1", f1, e.w1);
      check("width_out2", f2, e.w2);
    end
    check("busy_end", BUSY, 0);
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{p1: 8'd10,  p2: 8'd40,  w1: 26,  w2: 56};
    vecs[1] = '{p1: 8'd255, p2: 8'd0,   w1: 216, w2: 16};
    vecs[2] = '{p1: 8'd0,   p2: 8'd0,   w1: 16,  w2: 16};
    vecs[3] = '{p1: 8'd200, p2: 8'd201, w1: 216, w2: 216};
    vecs[4] = '{p1: 8'd7,   p2: 8'd199, w1: 23,  w2: 215};

    FPGA_RESET_N = 1'b0;
    PAD_TRG_N    = 1'b0;
    HRESET       = 1'b0;
    POS_WE       = 1'b0;
    PAD1_POS     = '0;
    PAD2_POS     = '0;
    #1;
    check("reset_out1", PAD1_OUT, 0);
    check("reset_out2", PAD2_OUT, 0);
    check("reset_busy", BUSY, 0);
    step();
    step();
    FPGA_RESET_N = 1'b1;
    step();

    // Trigger held low out of reset must not fire.
    for (int i = 0; i < 5; i++) begin
      line_tick();
      check("held_low_busy", {30'd0, PAD1_OUT, PAD2_OUT} | {31'd0, BUSY}, 0);
    end

    foreach (vecs[i]) begin
      write_pos(vecs[i].p1, vecs[i].p2);
      trigger(vecs[i].w1, vecs[i].w2, 1'b0, 8'd0, 8'd0);
      measure(0, 0, 8'd0, 8'd0);
    end

    // Retrigger at tick 20 ignored; write at tick 30 only affects the next frame.
    write_pos(8'd10, 8'd40);
    trigger(26, 56, 1'b0, 8'd0, 8'd0);
    measure(20, 30, 8'd0, 8'd0);
    trigger(16, 16, 1'b0, 8'd0, 8'd0);
    measure(0, 0, 8'd0, 8'd0);

    // Write in the trigger cycle: old shadow (50) used now, new value (5) next frame.
    write_pos(8'd50, 8'd50);
    trigger(66, 66, 1'b1, 8'd5, 8'd5);
    measure(0, 0, 8'd0, 8'd0);
    trigger(21, 21, 1'b0, 8'd0, 8'd0);
    measure(0, 0, 8'd0, 8'd0);

    // Asynchronous reset at tick 10 of an active pulse.
    write_pos(8'd10, 8'd40);
    trigger(26, 56, 1'b0, 8'd0, 8'd0);
    for (int k = 0; k < 10; k++) line_tick();
    check("pre_reset_out2", PAD2_OUT, 1);
    #3;
    FPGA_RESET_N = 1'b0;
    #1;
    check("async_reset_out1", PAD1_OUT, 0);
    check("async_reset_out2", PAD2_OUT, 0);
    check("async_reset_busy", BUSY, 0);
    sb.delete();
    step();
    FPGA_RESET_N = 1'b1;
    step();
    for (int k = 0; k < 60; k++) begin
      line_tick();
      if (BUSY) check("post_reset_quiet", BUSY, 0);
    end
    check("post_reset_idle", BUSY, 0);
    trigger(16, 16, 1'b0, 8'd0, 8'd0);
    measure(0, 0, 8'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
